// File: rtl/unified_mem_arbiter.sv
// Shared single-port memory arbiter for the MIPS pipeline: serves the MEM-stage load/store port
// ahead of the IF-stage fetch port, sequences each multi-cycle access and stalls the pipeline.
module unified_mem_arbiter #(
  parameter int unsigned MEM_LATENCY = 2,
  parameter int unsigned ADDR_W      = 32,
  parameter int unsigned DATA_W      = 32
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              inst_req,
  input  logic [ADDR_W-1:0] inst_adr,
  output logic [DATA_W-1:0] inst,
  output logic              inst_ready,
  input  logic              data_re,
  input  logic              data_we,
  input  logic [ADDR_W-1:0] data_adr,
  input  logic [DATA_W-1:0] data_wdata,
  output logic [DATA_W-1:0] data_rdata,
  output logic              data_ready,
  output logic [ADDR_W-1:0] mem_adr,
  output logic [DATA_W-1:0] mem_wdata,
  output logic              mem_re,
  output logic              mem_we,
  input  logic [DATA_W-1:0] mem_rdata,
  output logic              stall
);

  localparam int unsigned     CntW        = $clog2(MEM_LATENCY + 1);
  localparam logic [CntW-1:0] CntInit     = CntW'(MEM_LATENCY - 1);
  localparam logic [CntW-1:0] CntOne      = CntW'(1);
  localparam bit              SingleCycle = (MEM_LATENCY == 1);

  typedef enum logic [1:0] {StIdle, StDAcc, StIAcc, StResp} state_e;

  state_e          state;
  logic [CntW-1:0] cnt;
  logic            op_write;

  always_ff @(posedge clk) begin
    if (rst) begin
      state      <= StIdle;
      cnt        <= '0;
      op_write   <= 1'b0;
      inst       <= '0;
      data_rdata <= '0;
      mem_adr    <= '0;
      mem_wdata  <= '0;
      mem_re     <= 1'b0;
      mem_we     <= 1'b0;
      inst_ready <= 1'b0;
      data_ready <= 1'b0;
    end else begin
      inst_ready <= 1'b0;
      data_ready <= 1'b0;
      mem_we     <= 1'b0;
      unique case (state)
        StIdle: begin
          if (data_re || data_we) begin
            mem_adr   <= data_adr;
            mem_wdata <= data_wdata;
            op_write  <= data_we;
            mem_re    <= ~data_we;
            // The write strobe is registered, so it is raised on the edge entering the last cycle.
            mem_we    <= data_we & SingleCycle;
            cnt       <= CntInit;
            state     <= StDAcc;
          end else if (inst_req) begin
            mem_adr  <= inst_adr;
            op_write <= 1'b0;
            mem_re   <= 1'b1;
            cnt      <= CntInit;
            state    <= StIAcc;
          end
        end
        StDAcc, StIAcc: begin
          if (cnt != '0) begin
            cnt <= cnt - CntOne;
            if (op_write && cnt == CntOne) mem_we <= 1'b1;
          end else begin
            mem_re <= 1'b0;
            if (state == StIAcc) begin
              inst_ready <= 1'b1;
              if (!op_write) inst <= mem_rdata;
            end else begin
              data_ready <= 1'b1;
              if (!op_write) data_rdata <= mem_rdata;
            end
            state <= StResp;
          end
        end
        StResp: state <= StIdle;
        default: state <= StIdle;
      endcase
    end
  end

  assign stall = (inst_req & ~inst_ready) | ((data_re | data_we) & ~data_ready);

endmodule

// File: tb/tb_unified_mem_arbiter.sv
// Self-checking bench for unified_mem_arbiter: directed scenarios with literal expectations,
// then randomized requesters checked every cycle against a transaction-timeline model.
module tb_unified_mem_arbiter;

  localparam int L = 2;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        inst_req = 1'b0;
  logic [31:0] inst_adr = '0;
  logic [31:0] inst;
  logic        inst_ready;
  logic        data_re = 1'b0;
  logic        data_we = 1'b0;
  logic [31:0] data_adr = '0;
  logic [31:0] data_wdata = '0;
  logic [31:0] data_rdata;
  logic        data_ready;
  logic [31:0] mem_adr;
  logic [31:0] mem_wdata;
  logic        mem_re;
  logic        mem_we;
  logic [31:0] mem_rdata = '0;
  logic        stall;

  always #5 clk = ~clk;

  unified_mem_arbiter #(
    .MEM_LATENCY(L),
    .ADDR_W     (32),
    .DATA_W     (32)
  ) dut (
    .clk       (clk),
    .rst       (rst),
    .inst_req  (inst_req),
    .inst_adr  (inst_adr),
    .inst      (inst),
    .inst_ready(inst_ready),
    .data_re   (data_re),
    .data_we   (data_we),
    .data_adr  (data_adr),
    .data_wdata(data_wdata),
    .data_rdata(data_rdata),
    .data_ready(data_ready),
    .mem_adr   (mem_adr),
    .mem_wdata (mem_wdata),
    .mem_re    (mem_re),
    .mem_we    (mem_we),
    .mem_rdata (mem_rdata),
    .stall     (stall)
  );

  int checks = 0;
  int errors = 0;

  // Model: one transaction in flight; m_k is the cycle number within it (1..L access, L+1 ready).
  bit          m_busy = 1'b0;
  bit          m_port_d;
  bit          m_write;
  int          m_k;
  logic [31:0] m_adr, m_wdata;
  logic [31:0] m_inst = '0;
  logic [31:0] m_rdata = '0;
  bit          x_iready, x_dready;

  task automatic chk32(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h, expected %h (t=%0t)", name, act, exp, $time);
    end
  endtask

  task automatic chk1(input string name, input logic act, input logic exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %b, expected %b (t=%0t)", name, act, exp, $time);
    end
  endtask

  // One clock cycle: check registered outputs, apply this cycle's inputs, check stall, advance model.
  task automatic cycle(input logic r, input logic ir, input logic [31:0] ia, input logic dre,
                       input logic dwe, input logic [31:0] da, input logic [31:0] dw,
                       input logic [31:0] rd);
    bit e_re, e_we;
    @(negedge clk);
    e_re     = m_busy && m_k <= L && !m_write;
    e_we     = m_busy && m_k == L && m_write;
    x_iready = m_busy && m_k == L + 1 && !m_port_d;
    x_dready = m_busy && m_k == L + 1 && m_port_d;
    chk32("inst", inst, m_inst);
    chk32("data_rdata", data_rdata, m_rdata);
    chk1("mem_re", mem_re, e_re);
    chk1("mem_we", mem_we, e_we);
    chk1("inst_ready", inst_ready, x_iready);
    chk1("data_ready", data_ready, x_dready);
    if (e_re || e_we) chk32("mem_adr", mem_adr, m_adr);
    if (e_we) chk32("mem_wdata", mem_wdata, m_wdata);
    rst = r; inst_req = ir; inst_adr = ia; data_re = dre; data_we = dwe;
    data_adr = da; data_wdata = dw; mem_rdata = rd;
    #1;
    chk1("stall", stall, (ir & ~x_iready) | ((dre | dwe) & ~x_dready));
    if (r) begin
      m_busy = 1'b0; m_inst = '0; m_rdata = '0;
    end else if (m_busy) begin
      if (m_k == L && !m_write) begin
        if (m_port_d) m_rdata = rd;
        else m_inst = rd;
      end
      if (m_k == L + 1) m_busy = 1'b0;
      else m_k++;
    end else if (dre || dwe) begin
      m_busy = 1'b1; m_port_d = 1'b1; m_write = dwe; m_adr = da; m_wdata = dw; m_k = 1;
    end else if (ir) begin
      m_busy = 1'b1; m_port_d = 1'b0; m_write = 1'b0; m_adr = ia; m_k = 1;
    end
  endtask

  task automatic idle_cycle();
    cycle(1'b0, 1'b0, 32'h0, 1'b0, 1'b0, 32'h0, 32'h0, $urandom);
  endtask

  initial begin
    int          nwe, nre;
    bit          i_pend, d_pend, d_re, d_we, i_done, d_done, r;
    logic [31:0] i_adr, d_adr, d_wd;

    // Reset held 3 cycles with a fetch request pending.
    for (int i = 0; i < 3; i++) begin
      cycle(1'b1, 1'b1, 32'h40, 1'b0, 1'b0, 32'h0, 32'h0, $urandom);
      chk1("rst_mem_re", mem_re, 1'b0);
      chk1("rst_mem_we", mem_we, 1'b0);
      chk32("rst_outs", inst | data_rdata | mem_adr | mem_wdata, 32'h0);
      chk1("rst_readys", inst_ready | data_ready, 1'b0);
    end

    // Fetch from 0x40.
    cycle(1'b0, 1'b1, 32'h40, 1'b0, 1'b0, 32'h0, 32'h0, $urandom);
    chk1("f_stall0", stall, 1'b1);
    cycle(1'b0, 1'b1, 32'h40, 1'b0, 1'b0, 32'h0, 32'h0, $urandom);
    chk1("f_re1", mem_re, 1'b1);
    chk32("f_adr1", mem_adr, 32'h40);
    cycle(1'b0, 1'b1, 32'h40, 1'b0, 1'b0, 32'h0, 32'h0, 32'h8C010004);
    chk1("f_re2", mem_re, 1'b1);
    chk1("f_stall2", stall, 1'b1);
    cycle(1'b0, 1'b1, 32'h40, 1'b0, 1'b0, 32'h0, 32'h0, $urandom);
    chk1("f_ready3", inst_ready, 1'b1);
    chk32("f_inst3", inst, 32'h8C010004);
    chk1("f_stall3", stall, 1'b0);
    idle_cycle();

    // Simultaneous fetch 0x44 and load 0x100: data first.
    for (int c = 0; c <= 3; c++) begin
      cycle(1'b0, 1'b1, 32'h44, 1'b1, 1'b0, 32'h100, 32'h0, (c == 2) ? 32'h12345678 : $urandom);
      chk1("s_stall", stall, 1'b1);
      if (c == 1) chk32("s_adr1", mem_adr, 32'h100);
      if (c == 3) chk1("s_dready3", data_ready, 1'b1);
    end
    for (int c = 4; c <= 7; c++) begin
      cycle(1'b0, 1'b1, 32'h44, 1'b0, 1'b0, 32'h0, 32'h0, $urandom);
      if (c == 4) chk1("s_re4", mem_re, 1'b0);
      if (c == 5 || c == 6) begin
        chk32("s_adr56", mem_adr, 32'h44);
        chk1("s_stall56", stall, 1'b1);
      end
      if (c == 7) begin
        chk1("s_iready7", inst_ready, 1'b1);
        chk1("s_stall7", stall, 1'b0);
      end
    end
    chk32("s_rdata", data_rdata, 32'h12345678);
    idle_cycle();

    // Store 0xDEADBEEF to 0x200.
    for (int c = 0; c <= 3; c++) begin
      cycle(1'b0, 1'b0, 32'h0, 1'b0, 1'b1, 32'h200, 32'hDEADBEEF, $urandom);
      chk1("w_re", mem_re, 1'b0);
      chk1("w_we", mem_we, c == 2);
      if (c == 2) begin
        chk32("w_adr", mem_adr, 32'h200);
        chk32("w_wdata", mem_wdata, 32'hDEADBEEF);
      end
      chk1("w_dready", data_ready, c == 3);
    end
    idle_cycle();

    // data_re and data_we together act as a store.
    nwe = 0; nre = 0;
    for (int c = 0; c <= 3; c++) begin
      cycle(1'b0, 1'b0, 32'h0, 1'b1, 1'b1, 32'h180, 32'h55AA55AA, $urandom);
      nwe += int'(mem_we); nre += int'(mem_re);
    end
    chk1("b_dready", data_ready, 1'b1);
    chk32("b_we_count", nwe, 32'd1);
    chk32("b_re_count", nre, 32'd0);
    chk32("b_rdata", data_rdata, 32'h12345678);
    idle_cycle();

    // Reset during cycle 1 of a store, then the held request completes.
    nwe = 0;
    cycle(1'b0, 1'b0, 32'h0, 1'b0, 1'b1, 32'h300, 32'hCAFEF00D, $urandom);
    cycle(1'b1, 1'b0, 32'h0, 1'b0, 1'b1, 32'h300, 32'hCAFEF00D, $urandom);
    for (int c = 2; c <= 5; c++) begin
      cycle(1'b0, 1'b0, 32'h0, 1'b0, 1'b1, 32'h300, 32'hCAFEF00D, $urandom);
      if (c == 2) begin
        chk32("r_adr_cleared", mem_adr, 32'h0);
        chk1("r_dready2", data_ready, 1'b0);
      end
      if (c <= 3) nwe += int'(mem_we);
      if (c == 4) chk1("r_we4", mem_we, 1'b1);
      if (c == 5) chk1("r_dready5", data_ready, 1'b1);
    end
    chk32("r_no_aborted_we", nwe, 32'd0);
    idle_cycle();

    // Randomized requesters with withdrawals and occasional resets.
    i_pend = 0; d_pend = 0; i_done = 0; d_done = 0;
    i_adr = '0; d_adr = '0; d_wd = '0; d_re = 0; d_we = 0;
    for (int n = 0; n < 3000; n++) begin
      if (i_done) i_pend = 0;
      if (d_done) d_pend = 0;
      if (i_pend && $urandom_range(40) == 0) i_pend = 0;
      if (d_pend && $urandom_range(40) == 0) d_pend = 0;
      if (!i_pend && $urandom_range(2) == 0) begin
        i_pend = 1; i_adr = $urandom & 32'hFFFF_FFFC;
      end
      if (!d_pend && $urandom_range(2) == 0) begin
        int kind;
        kind = $urandom_range(2);
        d_pend = 1; d_re = (kind != 1); d_we = (kind != 0);
        d_adr = $urandom; d_wd = $urandom;
      end
      r = ($urandom_range(120) == 0);
      cycle(r, i_pend, i_pend ? i_adr : $urandom, d_pend & d_re, d_pend & d_we,
            d_pend ? d_adr : $urandom, d_pend ? d_wd : $urandom, $urandom);
      i_done = x_iready;
      d_done = x_dready;
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
